mux_sel_arbiter: RTL
====================

// Module: mux_sel_arbiter
// PURPOSE
//  Round-robin arbiter that sits directly upstream of the 4:1 2-bit case mux.
//  - Drives the mux's 2-bit select from four channel requests.
//  - Holds each grant for a burst of accepted beats, or until the request drops.
//  - Exposes a one-hot grant and a valid flag, so downstream logic knows when the
//    mux output is meaningful.
// PARAMETERS
//  BURST_LEN  4  beats (acked cycles) per grant before rotating; legal range 1..16
//  NUM_CH     4  channel count; fixed at 4 to match the 2-bit mux select
// PORTS
//  clk     input   1  single clock; all state updates on rising edge
//  rst     input   1  asynchronous, active-high reset
//  req     input   4  per-channel request; bit i = channel i wants the mux
//  ack     input   1  downstream accepted the current beat this cycle
//  select  output  2  registered mux select = index of granted channel
//  grant   output  4  registered one-hot grant; 4'b0000 when not valid
//  valid   output  1  registered; 1 while a grant is active (BUSY)
// BEHAVIOUR
//  Reset
//  - While rst=1, asynchronously: select=2'd0, grant=4'b0000, valid=0, state=IDLE,
//    beat count=0, last_sel=2'd3 (so channel 0 has first priority).
//  - Reset asserted mid-burst aborts the burst immediately. No beat is owed afterwards.
//  FSM states: IDLE, BUSY
//  - IDLE, req==0: remain IDLE; outputs hold their reset values except select
//    (select holds its last value).
//  - IDLE, req!=0: pick the first channel with req set, searching
//    last_sel+1, last_sel+2, last_sel+3, last_sel+4 mod 4.
//    - Register select=idx, grant=1<<idx, valid=1, count=0, state=BUSY.
//    - Latency: req seen at edge N -> valid=1 after edge N.
//  - BUSY, req[select]=0: release at this edge and ignore any ack this cycle.
//  - BUSY, req[select]=1 and ack=1 and count==BURST_LEN-1: release at this edge.
//  - BUSY, req[select]=1 and ack=1 and count<BURST_LEN-1: count+=1, stay BUSY.
//  - BUSY, ack=0: hold select, grant and count unchanged. No timeout.
//  - Release means: last_sel<=select, valid=0, grant=0, count=0, state=IDLE.
//    select keeps its value.
//  - Exactly one IDLE bubble cycle occurs between consecutive grants, even when
//    other requests are pending.
//  - A channel still requesting after its own release is re-eligible. It gets lowest
//    priority only relative to the other requesters.
//  - Changes on req bits other than req[select] during BUSY have no effect until the
//    next IDLE.
//  - count width is $clog2(BURST_LEN), with a minimum of 1 bit.
//    - BURST_LEN=1 releases on the first ack.
//    - count never exceeds BURST_LEN-1.
//  - Invariant: valid=1 <-> grant==(1<<select) <-> state==BUSY.
//    Otherwise grant==0 and valid==0.
//  - Inputs are assumed synchronous to clk. The block provides no input synchronizers.
// TESTING
//  T1  Reset mid-BUSY with select=2 -> grant=0, valid=0 and select=0 without a clock
//      edge. After release of reset, req=4'b0010 -> select=1 one edge later.
//  T2  BURST_LEN=4, req=4'b0100 held, ack=1 every cycle -> valid high exactly 4
//      cycles with select=2, 1 bubble cycle, then re-granted to select=2.
//  T3  req=4'b1111 held, ack=1 -> grant order 0,1,2,3,0. Each grant lasts 4 cycles,
//      with 1 bubble between grants.
//  T4  Channel 1 granted, ack pattern 1,0,0,1,1,0,1 -> release on the 4th ack
//      (7th cycle). select=1 is stable throughout.
//  T5  Channel 3 granted, req[3] dropped after 2 acks, with ack=1 on the drop cycle
//      -> valid=0 next edge, last_sel=3. Then req=4'b0011 -> select=0 (wrap-around).
//  T6  last_sel=1, req=4'b0011 in IDLE -> select=0. Toggling req[2] during that BUSY
//      has no effect on grant.

Source files
------------

// File: rtl/mux_sel_arbiter.sv
// -----------------------------------------------------------------------------
// mux_sel_arbiter
//
// Round-robin arbiter feeding the select of a 4:1 mux with 2-bit select.
// A granted channel keeps the mux for BURST_LEN accepted beats (cycles with
// ack=1), or until it drops its request, whichever comes first. Every grant is
// followed by exactly one IDLE bubble cycle before the next grant is issued.
//
// Parameters
//   BURST_LEN  accepted beats per grant before rotating (1..16)
//   NUM_CH     channel count; must stay 4 to match the 2-bit select
//
// Ports
//   clk     in   1  clock, all state changes on rising edge
//   rst     in   1  asynchronous, active-high reset
//   req     in   4  per-channel request, bit i = channel i
//   ack     in   1  downstream accepted the current beat
//   select  out  2  registered mux select (index of granted channel)
//   grant   out  4  registered one-hot grant, zero when not valid
//   valid   out  1  registered, high while a grant is active
// -----------------------------------------------------------------------------
`default_nettype none

module mux_sel_arbiter #(
    parameter int BURST_LEN = 4,
    parameter int NUM_CH    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              ack,
    output logic [1:0]        select,
    output logic [NUM_CH-1:0] grant,
    output logic              valid
);

    // Beat counter only needs to reach BURST_LEN-1; keep at least one bit so
    // BURST_LEN=1 still elaborates.
    localparam int             CNT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t              state_reg;
    logic [1:0]          select_reg;
    logic [NUM_CH-1:0]   grant_reg;
    logic                valid_reg;
    logic [CNT_W-1:0]    count_reg;
    logic [1:0]          last_sel_reg;

    // -------------------------------------------------------------------------
    // Rotating priority search. Candidate gi is the channel gi+1 positions
    // after the last served one, so the most recently served channel is
    // always checked last.
    // -------------------------------------------------------------------------
    logic [1:0]        cand_idx [NUM_CH];
    logic [NUM_CH-1:0] cand_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_cand
            assign cand_idx[gi] = last_sel_reg + 2'(gi + 1);
            assign cand_hit[gi] = req[cand_idx[gi]];
        end
    endgenerate

    logic [1:0] select_next;
    logic       req_any;

    always_comb begin
        select_next = cand_idx[0];
        // Walk from lowest to highest priority so the nearest hit wins.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (cand_hit[i]) begin
                select_next = cand_idx[i];
            end
        end
    end

    assign req_any = |req;

    // One-hot decode of the chosen index.
    logic [NUM_CH-1:0] grant_next;

    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_onehot
            assign grant_next[gi] = (select_next == 2'(gi));
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Release condition while BUSY: the owner withdrew its request (any ack in
    // that cycle is ignored), or the last beat of the burst was accepted.
    // -------------------------------------------------------------------------
    logic owner_req;
    logic last_beat;
    logic release_now;

    assign owner_req   = req[select_reg];
    assign last_beat   = ack && (count_reg == CNT_LAST);
    assign release_now = !owner_req || last_beat;

    // -------------------------------------------------------------------------
    // FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            select_reg   <= 2'd0;
            grant_reg    <= '0;
            valid_reg    <= 1'b0;
            count_reg    <= '0;
            // Channel 0 is first in line after reset.
            last_sel_reg <= 2'd3;
        end else begin
            case (state_reg)
                IDLE: begin
                    // select is left alone here so the mux stays on the last
                    // channel while nothing is granted.
                    if (req_any) begin
                        select_reg <= select_next;
                        grant_reg  <= grant_next;
                        valid_reg  <= 1'b1;
                        count_reg  <= '0;
                        state_reg  <= BUSY;
                    end
                end

                BUSY: begin
                    if (release_now) begin
                        last_sel_reg <= select_reg;
                        grant_reg    <= '0;
                        valid_reg    <= 1'b0;
                        count_reg    <= '0;
                        state_reg    <= IDLE;
                    end else if (ack) begin
                        count_reg <= count_reg + CNT_W'(1);
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    grant_reg <= '0;
                    valid_reg <= 1'b0;
                    count_reg <= '0;
                end
            endcase
        end
    end

    assign select = select_reg;
    assign grant  = grant_reg;
    assign valid  = valid_reg;

endmodule

`default_nettype wire
